// File: rtl/cam_search_engine.sv
// Ternary-search CAM with an encoded write port, per-entry valid bits and a
// two-stage search pipeline (match capture, then priority-encoded response).
// Optional macro CAM_MULTIHIT_EN adds the rsp_multi_hit output.
module cam_search_engine #(
  parameter int unsigned CAM_WIDTH  = 8,
  parameter int unsigned CAM_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CAM_WIDTH-1:0]  wr_data,
  input  logic                  wr_valid,
  input  logic                  search_req,
  output logic                  search_ready,
  input  logic [CAM_WIDTH-1:0]  search_word,
  input  logic [CAM_WIDTH-1:0]  dont_care_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
`ifdef CAM_MULTIHIT_EN
  output logic                  rsp_multi_hit,
`endif
  output logic [CAM_DEPTH-1:0]  rsp_match_vec
);

  logic [CAM_WIDTH-1:0]  mem_data [CAM_DEPTH];
  logic [CAM_DEPTH-1:0]  mem_valid;
  logic [CAM_DEPTH-1:0]  match_vec;

  logic                  s1_valid;
  logic [CAM_DEPTH-1:0]  s1_vec;

  logic                  adv;
  logic                  enc_hit;
  logic [ADDR_WIDTH-1:0] enc_addr;

  // Response register may be refilled when empty or being consumed.
  assign adv          = !rsp_valid || rsp_ready;
  assign search_ready = !s1_valid || adv;

  // Storage update; out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(CAM_DEPTH); i++) begin
        mem_data[i] <= '0;
      end
      mem_valid <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(CAM_DEPTH); i++) begin
        if (wr_addr == ADDR_WIDTH'(i)) begin
          if (wr_valid) begin
            mem_data[i] <= wr_data;
          end
          mem_valid[i] <= wr_valid;
        end
      end
    end
  end

  // Parallel ternary compare of the key against every stored word.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < int'(CAM_DEPTH); i++) begin
      match_vec[i] = mem_valid[i] &&
                     (((mem_data[i] ^ search_word) & ~dont_care_mask) == '0);
    end
  end

  // Stage 1: capture the match vector of an accepted search, hold when blocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else if (search_ready) begin
      s1_valid <= search_req;
      if (search_req) begin
        s1_vec <= match_vec;
      end
    end
  end

  // Lowest-index priority encoder over the stage-1 vector.
  always_comb begin
    enc_hit  = |s1_vec;
    enc_addr = '0;
    for (int i = int'(CAM_DEPTH) - 1; i >= 0; i--) begin
      if (s1_vec[i]) begin
        enc_addr = ADDR_WIDTH'(i);
      end
    end
  end

  // Stage 2: response register; data is left untouched when draining empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_addr      <= '0;
      rsp_match_vec <= '0;
    end else if (adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_hit       <= enc_hit;
        rsp_addr      <= enc_addr;
        rsp_match_vec <= s1_vec;
      end
    end
  end

`ifdef CAM_MULTIHIT_EN
  // Two or more set bits: clearing the lowest set bit still leaves one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_multi_hit <= 1'b0;
    end else if (adv && s1_valid) begin
      rsp_multi_hit <= (s1_vec & (s1_vec - CAM_DEPTH'(1))) != '0;
    end
  end
`endif

endmodule

// File: tb/tb_cam_search_engine.sv
// Self-checking bench for cam_search_engine: directed scenarios plus a
// randomized run scored against a queue-based reference model.
module tb_cam_search_engine;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         wr_valid;
  logic         search_req;
  logic         search_ready;
  logic [W-1:0] search_word;
  logic [W-1:0] dont_care_mask;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_hit;
  logic [A-1:0] rsp_addr;
  logic [D-1:0] rsp_match_vec;
`ifdef CAM_MULTIHIT_EN
  logic         rsp_multi_hit;
`endif

  cam_search_engine #(
    .CAM_WIDTH (W),
    .CAM_DEPTH (D),
    .ADDR_WIDTH(A)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .search_req    (search_req),
    .search_ready  (search_ready),
    .search_word   (search_word),
    .dont_care_mask(dont_care_mask),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_addr      (rsp_addr),
`ifdef CAM_MULTIHIT_EN
    .rsp_multi_hit (rsp_multi_hit),
`endif
    .rsp_match_vec (rsp_match_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: stored words, and a queue of accepted searches in order.
  typedef struct {
    logic [D-1:0] vec;
    int           ready_at;
  } item_t;

  logic [W-1:0] m_data [D];
  logic [D-1:0] m_valid;
  item_t        q[$];
  int           cyc = 0;

  function automatic logic [D-1:0] model_match(input logic [W-1:0] key,
                                               input logic [W-1:0] mask);
    logic [D-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) begin
      v[i] = m_valid[i] && (((m_data[i] ^ key) & ~mask) == '0);
    end
    return v;
  endfunction

  function automatic logic [A-1:0] lowest(input logic [D-1:0] v);
    for (int i = 0; i < D; i++) begin
      if (v[i]) return A'(i);
    end
    return '0;
  endfunction

  // A result is visible one edge after acceptance, once nothing is ahead of it.
  function automatic logic exp_rsp_valid();
    return (q.size() > 0) && (cyc >= q[0].ready_at);
  endfunction

  // At most two searches can be outstanding; the second slot frees on consume.
  function automatic logic exp_ready();
    return (q.size() < 2) || (exp_rsp_valid() && rsp_ready);
  endfunction

  function automatic void model_clear();
    q.delete();
    for (int i = 0; i < D; i++) m_data[i] = '0;
    m_valid = '0;
  endfunction

  // One rising edge, with the model following the inputs presented for it.
  task automatic clock_edge();
    logic         acc;
    logic         pop;
    logic [D-1:0] v;
    acc = search_req && exp_ready();
    pop = exp_rsp_valid() && rsp_ready;
    v   = model_match(search_word, dont_care_mask);
    @(posedge clk);
    cyc++;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{vec: v, ready_at: cyc + 1});
    if (wr_en && int'(wr_addr) < D) begin
      if (wr_valid) m_data[wr_addr] = wr_data;
      m_valid[wr_addr] = wr_valid;
    end
    #2;
  endtask

  task automatic drive_idle();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_valid = 0;
    search_req = 0; search_word = '0; dont_care_mask = '0;
    rsp_ready = 1;
  endtask

  task automatic do_write(input int addr, input logic [W-1:0] data, input logic vld);
    wr_en = 1; wr_addr = A'(addr); wr_data = data; wr_valid = vld;
    clock_edge();
    wr_en = 0;
  endtask

  task automatic drain();
    search_req = 0; rsp_ready = 1;
    repeat (3) clock_edge();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 0;
    model_clear();
    #1;
    checks++;
    if (rsp_valid !== 0 || rsp_hit !== 0 || rsp_addr !== 0 || rsp_match_vec !== 0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b h=%b a=%0d m=%h exp all zero",
               rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (search_ready !== 1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", search_ready);
    end
    search_req = 1; search_word = 8'h5A; dont_care_mask = 8'h00;
    clock_edge();
    search_req = 0;
    #1;
    checks++;
    if (rsp_valid !== 0) begin
      failures++;
      $display("FAIL empty_latency1 rsp_valid got=%b exp=0", rsp_valid);
    end
    clock_edge();
    #1;
    checks++;
    if (rsp_valid !== 1 || rsp_hit !== 0 || rsp_addr !== 0 || rsp_match_vec !== 0) begin
      failures++;
      $display("FAIL empty_search got v=%b h=%b a=%0d m=%h exp v=1 h=0 a=0 m=00",
               rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
    end
    drain();
  endtask

  task automatic test_multi_hit();
    do_write(3, 8'h5A, 1);
    do_write(6, 8'h5A, 1);
    search_req = 1; search_word = 8'h5A; dont_care_mask = 8'h00;
    clock_edge();
    search_req = 0;
    clock_edge();
    #1;
    checks++;
    if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_addr !== 3 || rsp_match_vec !== 8'h48) begin
      failures++;
      $display("FAIL multi_hit got v=%b h=%b a=%0d m=%h exp v=1 h=1 a=3 m=48",
               rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
    end
`ifdef CAM_MULTIHIT_EN
    checks++;
    if (rsp_multi_hit !== 1) begin
      failures++;
      $display("FAIL multi_flag got=%b exp=1", rsp_multi_hit);
    end
`endif
    drain();
  endtask

  task automatic test_mask_invalidate();
    do_write(2, 8'hF0, 1);
    for (int pass = 0; pass < 2; pass++) begin
      search_req = 1; search_word = 8'hFF; dont_care_mask = 8'h0F;
      clock_edge();
      search_req = 0;
      clock_edge();
      #1;
      checks++;
      if (pass == 0) begin
        if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_addr !== 2 || rsp_match_vec !== 8'h04) begin
          failures++;
          $display("FAIL mask_hit got v=%b h=%b a=%0d m=%h exp v=1 h=1 a=2 m=04",
                   rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
        end
        drain();
        do_write(2, 8'hF0, 0);
      end else begin
        if (rsp_valid !== 1 || rsp_hit !== 0 || rsp_addr !== 0 || rsp_match_vec !== 8'h00) begin
          failures++;
          $display("FAIL invalidated_miss got v=%b h=%b a=%0d m=%h exp v=1 h=0 a=0 m=00",
                   rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
        end
      end
    end
    drain();
  endtask

  task automatic test_same_edge_write();
    wr_en = 1; wr_addr = 3'd1; wr_data = 8'h11; wr_valid = 1;
    search_req = 1; search_word = 8'h11; dont_care_mask = 8'h00;
    clock_edge();
    wr_en = 0;
    clock_edge();
    search_req = 0;
    #1;
    checks++;
    if (rsp_valid !== 1 || rsp_hit !== 0 || rsp_match_vec !== 8'h00) begin
      failures++;
      $display("FAIL same_edge_miss got v=%b h=%b m=%h exp v=1 h=0 m=00",
               rsp_valid, rsp_hit, rsp_match_vec);
    end
    clock_edge();
    #1;
    checks++;
    if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_addr !== 1 || rsp_match_vec !== 8'h02) begin
      failures++;
      $display("FAIL next_edge_hit got v=%b h=%b a=%0d m=%h exp v=1 h=1 a=1 m=02",
               rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] keys [4];
    logic         rdy  [4];
    keys = '{8'h5A, 8'h11, 8'hF0, 8'h00};
    rdy  = '{1'b1, 1'b1, 1'b0, 1'b0};
    rsp_ready = 0;
    dont_care_mask = 8'h00;
    for (int c = 0; c < 4; c++) begin
      search_req = 1; search_word = keys[c];
      #1;
      checks++;
      if (search_ready !== rdy[c]) begin
        failures++;
        $display("FAIL bp_ready cycle=%0d got=%b exp=%b", c, search_ready, rdy[c]);
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_addr !== 3 || rsp_match_vec !== 8'h48) begin
          failures++;
          $display("FAIL bp_hold cycle=%0d got v=%b h=%b a=%0d m=%h exp v=1 h=1 a=3 m=48",
                   c, rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
        end
      end
      clock_edge();
    end
    search_req = 0; rsp_ready = 1;
    #1;
    checks++;
    if (search_ready !== 1 || rsp_addr !== 3) begin
      failures++;
      $display("FAIL bp_release got ready=%b a=%0d exp ready=1 a=3", search_ready, rsp_addr);
    end
    clock_edge();
    #1;
    checks++;
    if (rsp_valid !== 1 || rsp_hit !== 1 || rsp_addr !== 1 || rsp_match_vec !== 8'h02) begin
      failures++;
      $display("FAIL bp_second got v=%b h=%b a=%0d m=%h exp v=1 h=1 a=1 m=02",
               rsp_valid, rsp_hit, rsp_addr, rsp_match_vec);
    end
    clock_edge();
    #1;
    checks++;
    if (rsp_valid !== 0 || rsp_addr !== 1 || rsp_match_vec !== 8'h02) begin
      failures++;
      $display("FAIL bp_drained got v=%b a=%0d m=%h exp v=0 a=1 m=02",
               rsp_valid, rsp_addr, rsp_match_vec);
    end
    drain();
  endtask

  task automatic test_random();
    logic [W-1:0] pool [4];
    logic [D-1:0] v;
    pool = '{8'h5A, 8'h11, 8'hF0, 8'hA5};
    for (int n = 0; n < 400; n++) begin
      wr_en    = ($urandom_range(0, 9) < 3);
      wr_addr  = A'($urandom_range(0, D - 1));
      wr_data  = ($urandom_range(0, 3) == 0) ? W'($urandom) : pool[$urandom_range(0, 3)];
      wr_valid = ($urandom_range(0, 4) != 0);
      search_req  = ($urandom_range(0, 9) < 7);
      search_word = pool[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0:       dont_care_mask = 8'h00;
        1:       dont_care_mask = 8'hFF;
        default: dont_care_mask = W'($urandom) & W'($urandom);
      endcase
      rsp_ready = ($urandom_range(0, 9) < 6);
      #1;
      checks++;
      if (search_ready !== exp_ready()) begin
        failures++;
        $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, search_ready, exp_ready());
      end
      checks++;
      if (rsp_valid !== exp_rsp_valid()) begin
        failures++;
        $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, rsp_valid, exp_rsp_valid());
      end
      if (exp_rsp_valid()) begin
        v = q[0].vec;
        checks++;
        if (rsp_match_vec !== v || rsp_hit !== (|v) || rsp_addr !== lowest(v)) begin
          failures++;
          $display("FAIL rnd_rsp n=%0d got h=%b a=%0d m=%h exp h=%b a=%0d m=%h",
                   n, rsp_hit, rsp_addr, rsp_match_vec, |v, lowest(v), v);
        end
`ifdef CAM_MULTIHIT_EN
        checks++;
        if (rsp_multi_hit !== ($countones(v) >= 2)) begin
          failures++;
          $display("FAIL rnd_multi n=%0d got=%b exp=%b", n, rsp_multi_hit,
                   $countones(v) >= 2);
        end
`endif
      end
      clock_edge();
    end
    wr_en = 0;
    drain();
  endtask

  task automatic test_reset_inflight();
    do_write(4, 8'h3C, 1);
    rsp_ready = 0;
    search_req = 1; search_word = 8'h3C; dont_care_mask = 8'h00;
    clock_edge();
    clock_edge();
    search_req = 0;
    rst = 0;
    model_clear();
    #1;
    checks++;
    if (rsp_valid !== 0 || rsp_hit !== 0 || rsp_addr !== 0 || rsp_match_vec !== 0 ||
        search_ready !== 1) begin
      failures++;
      $display("FAIL inflight_reset got v=%b h=%b a=%0d m=%h rdy=%b exp zeros rdy=1",
               rsp_valid, rsp_hit, rsp_addr, rsp_match_vec, search_ready);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1;
    rsp_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 0) begin
        failures++;
        $display("FAIL inflight_dropped cycle=%0d got=%b exp=0", c, rsp_valid);
      end
      clock_edge();
    end
    search_req = 1; search_word = 8'h00; dont_care_mask = 8'hFF;
    clock_edge();
    search_req = 0;
    clock_edge();
    #1;
    checks++;
    if (rsp_valid !== 1 || rsp_hit !== 0 || rsp_match_vec !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_empty got v=%b h=%b m=%h exp v=1 h=0 m=00",
               rsp_valid, rsp_hit, rsp_match_vec);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_multi_hit();
    test_mask_invalidate();
    test_same_edge_write();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
